// File: rtl/bus_pkg.sv
// Shared definitions for the 5-bit data bus: field widths, idle grant code and tenure FSM states.
// Also intended for the bus master and arbiter.
package bus_pkg;

  localparam int BUS_W     = 5;
  localparam int ADDR_W    = 2;
  localparam int PAYLOAD_W = 3;
  localparam int ID_W      = 3;

  localparam logic [ID_W-1:0] GRANT_IDLE = 3'b000;

  typedef enum logic [1:0] {
    TEN_IDLE    = 2'b00,
    TEN_CAPTURE = 2'b01,
    TEN_HOLD    = 2'b10
  } tenure_state_e;

  function automatic logic [ADDR_W-1:0] bus_addr(input logic [BUS_W-1:0] word);
    return word[BUS_W-1 -: ADDR_W];
  endfunction

  function automatic logic [PAYLOAD_W-1:0] bus_payload(input logic [BUS_W-1:0] word);
    return word[PAYLOAD_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word: a push into an empty FIFO is visible
// on head_data right after the pushing edge. DEPTH must be a power of two, at least 2.
module sync_fifo #(
  parameter  int WIDTH = 6,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             head_valid_q, head_valid_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic             full_s, empty_s, push_ok_s, pop_ok_s;

  // Pointer, occupancy and next-head computation.
  always_comb begin
    full_s    = (count_q == CNT_W'(DEPTH));
    empty_s   = (count_q == {CNT_W{1'b0}});
    pop_ok_s  = pop & ~empty_s;
    push_ok_s = push & (~full_s | pop_ok_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // The new head is the word being written when it lands in the slot the read pointer moves to.
    if (count_d == {CNT_W{1'b0}}) begin
      head_valid_d = 1'b0;
      head_data_d  = {WIDTH{1'b0}};
    end else if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
      head_valid_d = 1'b1;
      head_data_d  = push_data;
    end else begin
      head_valid_d = 1'b1;
      head_data_d  = mem_q[rd_ptr_d];
    end
  end

  // Control and head registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      head_valid_q <= 1'b0;
      head_data_q  <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
    end
  end

  // Storage array; not reset, contents qualified by count.
  always_ff @(posedge clk) begin
    if (push_ok_s && !reset) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign full       = full_s;
  assign count      = count_q;
  assign head_valid = head_valid_q;
  assign head_data  = head_data_q;

endmodule

// File: rtl/bus_slave_rx.sv
// Buffered bus responder: captures one address-matching word per grant tenure,
// tags it with the master ID and queues it for a valid/ready consumer.
module bus_slave_rx
  import bus_pkg::*;
#(
  parameter  logic [ADDR_W-1:0] SLAVE_ADDR = 2'd0,
  parameter  int                DEPTH      = 4,
  localparam int                CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ID_W-1:0]           grant,
  input  logic [BUS_W-1:0]          data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ID_W+PAYLOAD_W-1:0] out_data,
  output logic [CNT_W-1:0]          count,
  output logic                      overflow
);

  tenure_state_e                 state_q, state_d;
  logic [ID_W-1:0]               grant_q, grant_d;
  logic                          overflow_q, overflow_d;
  logic                          push_s, pop_s, fifo_full_s;
  logic [ID_W+PAYLOAD_W-1:0]     push_word_s;

  // Tenure state, previous grant and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= TEN_IDLE;
      grant_q    <= GRANT_IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      overflow_q <= overflow_d;
    end
  end

  // Next tenure state: a change to a different nonzero ID starts a fresh tenure.
  always_comb begin
    state_d = state_q;
    grant_d = grant;
    case (state_q)
      TEN_IDLE: begin
        if (grant != GRANT_IDLE) begin
          state_d = TEN_CAPTURE;
        end else begin
          state_d = TEN_IDLE;
        end
      end
      TEN_CAPTURE, TEN_HOLD: begin
        if (grant == GRANT_IDLE) begin
          state_d = TEN_IDLE;
        end else if (grant != grant_q) begin
          state_d = TEN_CAPTURE;
        end else begin
          state_d = TEN_HOLD;
        end
      end
      default: state_d = TEN_IDLE;
    endcase
  end

  // Capture decode and overflow update.
  always_comb begin
    push_word_s = {grant_q, bus_payload(data)};
    pop_s       = out_valid & out_ready;
    if ((state_q == TEN_CAPTURE) && (bus_addr(data) == SLAVE_ADDR)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (push_s && fifo_full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  sync_fifo #(
    .WIDTH(ID_W + PAYLOAD_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_word_s),
    .pop       (out_ready),
    .full      (fifo_full_s),
    .count     (count),
    .head_valid(out_valid),
    .head_data (out_data)
  );

  assign overflow = overflow_q;

endmodule

// File: tb/tb_bus_slave_rx.sv
// Directed self-checking bench for bus_slave_rx (SLAVE_ADDR=2, DEPTH=4).
module tb_bus_slave_rx;

  localparam int         DEPTH = 4;
  localparam logic [1:0] ADDR  = 2'd2;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] grant;
  logic [4:0] data;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_data;
  logic [2:0] count;
  logic       overflow;

  int asserts = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  bus_slave_rx #(.SLAVE_ADDR(ADDR), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .grant(grant), .data(data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .overflow(overflow)
  );

  task automatic step(input logic [2:0] g, input logic [4:0] d, input logic rdy);
    grant = g; data = d; out_ready = rdy;
    @(posedge clk); #1;
  endtask

  // Two-cycle tenure then an idle cycle; a matching word is pushed on the second edge.
  task automatic tenure(input logic [2:0] id, input logic [4:0] d);
    step(id, d, 1'b0);
    step(id, d, 1'b0);
    step(3'd0, 5'd0, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(3'd0, 5'd0, 1'b0);
    step(3'd0, 5'd0, 1'b0);
    reset = 1'b0;
    asserts++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    asserts++; if (out_data !== 6'd0) begin fails++; $display("FAIL reset_data: got %b want 000000", out_data); end
    asserts++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
    asserts++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_single;
    step(3'd2, {ADDR, 3'b101}, 1'b0);
    asserts++; if (count !== 3'd0) begin fails++; $display("FAIL single_pre_count: got %0d want 0", count); end
    // Capture cycle with out_ready high on an empty FIFO: no pop possible.
    step(3'd2, {ADDR, 3'b101}, 1'b1);
    asserts++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", out_valid); end
    asserts++; if (out_data !== 6'b010_101) begin fails++; $display("FAIL single_data: got %b want 010101", out_data); end
    asserts++; if (count !== 3'd1) begin fails++; $display("FAIL single_count: got %0d want 1", count); end
    step(3'd2, {ADDR, 3'b101}, 1'b0);
    step(3'd0, 5'd0, 1'b0);
    asserts++; if (count !== 3'd1) begin fails++; $display("FAIL single_hold_count: got %0d want 1", count); end
    asserts++; if (out_data !== 6'b010_101) begin fails++; $display("FAIL single_stable: got %b want 010101", out_data); end
    step(3'd0, 5'd0, 1'b1);
    asserts++; if (count !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL single_drain: got count %0d valid %b want 0 0", count, out_valid); end
  endtask

  task automatic test_back_to_back;
    step(3'd3, {ADDR, 3'b001}, 1'b0);
    step(3'd3, {ADDR, 3'b001}, 1'b0);
    step(3'd3, {ADDR, 3'b001}, 1'b0);
    step(3'd1, {ADDR, 3'b110}, 1'b0);
    step(3'd1, {ADDR, 3'b110}, 1'b0);
    step(3'd1, {ADDR, 3'b110}, 1'b0);
    step(3'd0, 5'd0, 1'b0);
    asserts++; if (count !== 3'd2) begin fails++; $display("FAIL b2b_count: got %0d want 2", count); end
    asserts++; if (out_data !== 6'b011_001) begin fails++; $display("FAIL b2b_first: got %b want 011001", out_data); end
    step(3'd0, 5'd0, 1'b1);
    asserts++; if (out_data !== 6'b001_110) begin fails++; $display("FAIL b2b_second: got %b want 001110", out_data); end
    step(3'd0, 5'd0, 1'b1);
    asserts++; if (count !== 3'd0) begin fails++; $display("FAIL b2b_drain: got %0d want 0", count); end
  endtask

  task automatic test_mismatch;
    // Foreign address at capture, matching address only during hold: nothing queued.
    step(3'd4, {2'd1, 3'b111}, 1'b0);
    step(3'd4, {2'd1, 3'b111}, 1'b0);
    step(3'd4, {ADDR, 3'b111}, 1'b0);
    step(3'd0, 5'd0, 1'b0);
    asserts++; if (count !== 3'd0) begin fails++; $display("FAIL mismatch_count: got %0d want 0", count); end
    asserts++; if (overflow !== 1'b0) begin fails++; $display("FAIL mismatch_overflow: got %b want 0", overflow); end
    asserts++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mismatch_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_overflow;
    logic [2:0] ids  [5] = '{3'd5, 3'd6, 3'd7, 3'd1, 3'd2};
    logic [2:0] pays [5] = '{3'b011, 3'b100, 3'b111, 3'b000, 3'b010};
    logic [5:0] exp  [4] = '{6'b101_011, 6'b110_100, 6'b111_111, 6'b001_000};
    for (int i = 0; i < 4; i++) tenure(ids[i], {ADDR, pays[i]});
    asserts++; if (count !== 3'd4 || overflow !== 1'b0) begin fails++; $display("FAIL ovf_fill: got count %0d ovf %b want 4 0", count, overflow); end
    tenure(ids[4], {ADDR, pays[4]});
    asserts++; if (count !== 3'd4) begin fails++; $display("FAIL ovf_count: got %0d want 4", count); end
    asserts++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      asserts++; if (out_data !== exp[i]) begin fails++; $display("FAIL ovf_drain%0d: got %b want %b", i, out_data, exp[i]); end
      step(3'd0, 5'd0, 1'b1);
    end
    asserts++; if (count !== 3'd0 || overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got count %0d ovf %b want 0 1", count, overflow); end
    reset = 1'b1;
    step(3'd0, 5'd0, 1'b0);
    reset = 1'b0;
    asserts++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_full_push_pop;
    logic [5:0] model [$];
    logic [2:0] id;
    logic [2:0] pay;
    for (int i = 0; i < 4; i++) begin
      tenure(3'(i + 1), {ADDR, 3'(i)});
      model.push_back({3'(i + 1), 3'(i)});
    end
    for (int k = 0; k < 3 * DEPTH; k++) begin
      id  = 3'((k % 7) + 1);
      pay = 3'(k + 3);
      step(id, {ADDR, pay}, 1'b0);
      asserts++; if (out_data !== model[0]) begin fails++; $display("FAIL pp_head%0d: got %b want %b", k, out_data, model[0]); end
      step(id, {ADDR, pay}, 1'b1);
      void'(model.pop_front());
      model.push_back({id, pay});
      asserts++; if (count !== 3'd4 || overflow !== 1'b0) begin fails++; $display("FAIL pp_full%0d: got count %0d ovf %b want 4 0", k, count, overflow); end
      step(3'd0, 5'd0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      asserts++; if (out_data !== model[i]) begin fails++; $display("FAIL pp_drain%0d: got %b want %b", i, out_data, model[i]); end
      step(3'd0, 5'd0, 1'b1);
    end
    asserts++; if (count !== 3'd0) begin fails++; $display("FAIL pp_empty: got %0d want 0", count); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) tenure(3'(i + 1), {ADDR, 3'(i + 1)});
    step(3'd0, 5'd0, 1'b1);
    step(3'd0, 5'd0, 1'b1);
    asserts++; if (count !== 3'd2 || overflow !== 1'b1) begin fails++; $display("FAIL mid_pre: got count %0d ovf %b want 2 1", count, overflow); end
    step(3'd3, {ADDR, 3'b110}, 1'b0);
    // Reset lands on what would be the capture edge.
    reset = 1'b1;
    step(3'd3, {ADDR, 3'b110}, 1'b0);
    reset = 1'b0;
    asserts++; if (count !== 3'd0) begin fails++; $display("FAIL mid_count: got %0d want 0", count); end
    asserts++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    asserts++; if (overflow !== 1'b0) begin fails++; $display("FAIL mid_overflow: got %b want 0", overflow); end
    step(3'd3, {ADDR, 3'b110}, 1'b0);
    asserts++; if (count !== 3'd0) begin fails++; $display("FAIL mid_newten: got %0d want 0", count); end
    step(3'd3, {ADDR, 3'b110}, 1'b0);
    asserts++; if (count !== 3'd1 || out_data !== 6'b011_110) begin fails++; $display("FAIL mid_recapture: got count %0d data %b want 1 011110", count, out_data); end
    step(3'd0, 5'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; grant = 3'd0; data = 5'd0; out_ready = 1'b0;
    test_reset;
    test_single;
    test_back_to_back;
    test_mismatch;
    test_overflow;
    test_full_push_pop;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/bus_slave_rx.md
# bus_slave_rx

Buffered responder for the shared 5-bit data bus. Sits beside the simple bus slaves and captures one word per grant tenure when the word's address field matches its own, tags it with the granted master's ID and queues it in a small FIFO. A local consumer drains the FIFO through a valid/ready handshake.

## Interface
- `SLAVE_ADDR`, default 0: 2-bit address this responder answers to (0..3).
- `DEPTH`, default 4: FIFO entries; must be a power of two, at least 2.
- `clk` input, 1 bit: bus clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `grant` input, 3 bits: arbiter grant bus; 0 means idle, 1..4 means that master ID owns the bus.
- `data` input, 5 bits: bus word `{addr[1:0], payload[2:0]}`.
- `out_valid` output, 1 bit: FIFO head is valid.
- `out_ready` input, 1 bit: consumer accepts the head.
- `out_data` output, 6 bits: `{master_id[2:0], payload[2:0]}` at the FIFO head.
- `count` output, clog2(DEPTH)+1 bits: current FIFO occupancy.
- `overflow` output, 1 bit: sticky flag, set when a matching word is dropped.

## Operation
- Tenure FSM has three states:
  - IDLE: `grant`==0.
  - CAPTURE: first cycle of a tenure.
  - HOLD: remaining cycles of the same tenure.
- FSM transitions:
  - IDLE→CAPTURE when `grant`≠0.
  - CAPTURE→HOLD when `grant` is unchanged and nonzero.
  - CAPTURE/HOLD→IDLE when `grant`==0.
  - CAPTURE/HOLD→CAPTURE when `grant` changes to a different nonzero ID (back-to-back tenure).
- Transitions are decided from the registered previous `grant` (`grant_q`) and the current `grant`.
- Capture: only in CAPTURE, and only if `data[4:3]`==`SLAVE_ADDR`. On capture, push `{grant_q, data[2:0]}`, where `grant_q` equals `grant` at that cycle.
- Exactly one push per tenure. Words during HOLD are ignored.
- A nonmatching address in CAPTURE produces no push and leaves `overflow` untouched.
- Pop: on any cycle where `out_valid && out_ready`.
- Full FIFO with a push and no pop in the same cycle: the word is dropped, `overflow` is set, and `count` is unchanged.
- Full FIFO with a push and a pop in the same cycle: both succeed, `count` is unchanged, and `overflow` is not set.
- Empty FIFO with a push and `out_ready`=1: a pop in that cycle is impossible because `out_valid`=0. The word appears on the next cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` = pushes − pops, range 0..DEPTH.
- `overflow` is cleared only by `reset`.
- Illegal grant values 5..7 are treated as nonzero IDs: tenure tracking works as normal and the ID is stored verbatim.

## Timing
- Reset values:
  - FSM = IDLE, `grant_q` = 0.
  - Pointers = 0, `count` = 0.
  - `out_valid` = 0, `out_data` = 0, `overflow` = 0.
- Reset takes priority over all activity, including mid-tenure. After reset deassertion with `grant` still nonzero, the next cycle is a CAPTURE (a new tenure).
- Latency: a word sampled on edge N is visible on `out_data` with `out_valid`=1 after edge N (registered output), i.e. usable from cycle N+1.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- `count` and `overflow` are registered and update on the same edge as the push or pop.
- No combinational path from `out_ready` to `out_valid`.

## Structure
- Shared package `bus_pkg` holds:
  - `BUS_W`=5, `ADDR_W`=2, `PAYLOAD_W`=3, `ID_W`=3.
  - `GRANT_IDLE`=3'b000.
  - The tenure FSM state enum.
- The same package is to be reused by the master and arbiter in later revisions.
- One sub-module: `sync_fifo` (parameters WIDTH, DEPTH), a synchronous FIFO with push/pop, full/empty, count and a registered head. It is instantiated once.
- The FSM and address decode live in `bus_slave_rx`.

## Test plan
- Reset, then `grant`=2 for 3 cycles with `data`=`{SLAVE_ADDR,3'b101}` → exactly one entry; `out_data`=6'b010_101 one cycle after capture; `count`=1.
- Back-to-back grants 3 then 1 with no idle gap, both words addressed here (payloads 3'b001, 3'b110) → two entries in order, 6'b011_001 then 6'b001_110.
- Word addressed to a different slave during CAPTURE → no push; `count`=0; `overflow`=0.
- DEPTH+1 matching tenures with `out_ready`=0 → `count`=DEPTH, `overflow`=1, and the first DEPTH entries drain intact in order.
- FIFO full with a push and a pop in the same cycle → `count` stays DEPTH, `overflow` stays 0, and the pointers wrap correctly over 3×DEPTH transfers.
- `reset` asserted mid-tenure with 2 entries queued → next cycle `count`=0, `out_valid`=0, `overflow`=0. If `grant` is still held, a new capture occurs on the first cycle after reset.
